// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle multiply/divide sequencer that owns the HI/LO registers.
// The result is computed when the op issues and held in pending registers. A countdown
// models the latency, and HI/LO are written when the countdown expires.
// Ports:
//   clk, reset       rising-edge clock; synchronous active-high reset
//   Start            EX-stage MULDIV op valid, sampled at the clock edge
//   MULDIVMode[3:0]  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others no-op
//   A, B [31:0]      forwarded rs / rt operands
//   HILOSel          1 selects HI, 0 selects LO on HILOOut
//   Busy             registered; high while a mult/div is in flight
//   HILOOut [31:0]   HILOSel ? HI : LO
//   HI, LO [31:0]    architectural HI/LO registers
module muldiv_seq #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MULDIVMode,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HILOSel,
    output logic        Busy,
    output logic [31:0] HILOOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        busy_n;
    logic [31:0] hi_n, lo_n;
    logic [31:0] pend_hi, pend_lo, pend_hi_n, pend_lo_n;

    // Arithmetic results, computed combinationally and captured at issue.
    logic signed [63:0] a_ext, b_ext, prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        q_s, r_s, q_u, r_u;

    assign a_ext  = {{32{A[31]}}, A};
    assign b_ext  = {{32{B[31]}}, B};
    assign prod_s = a_ext * b_ext;
    assign prod_u = {32'd0, A} * {32'd0, B};

    always_comb begin
        q_s = 32'd0;
        r_s = 32'd0;
        q_u = 32'd0;
        r_u = 32'd0;
        if (B == 32'd0) begin
            // Divide by zero: all-ones quotient, dividend left in the remainder.
            q_s = 32'hFFFF_FFFF;
            r_s = A;
            q_u = 32'hFFFF_FFFF;
            r_u = A;
        end else begin
            if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                // -2^31 / -1 overflows; force the wrapped quotient explicitly.
                q_s = 32'h8000_0000;
                r_s = 32'd0;
            end else begin
                q_s = $signed(A) / $signed(B);
                r_s = $signed(A) % $signed(B);
            end
            q_u = A / B;
            r_u = A % B;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        busy_n    = Busy;
        hi_n      = HI;
        lo_n      = LO;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        case (state)
            IDLE: begin
                if (Start) begin
                    case (MULDIVMode)
                        4'd0: begin
                            pend_hi_n = prod_s[63:32];
                            pend_lo_n = prod_s[31:0];
                            cnt_n     = 4'(MULT_CYCLES);
                            busy_n    = 1'b1;
                            state_n   = RUN;
                        end
                        4'd1: begin
                            pend_hi_n = prod_u[63:32];
                            pend_lo_n = prod_u[31:0];
                            cnt_n     = 4'(MULT_CYCLES);
                            busy_n    = 1'b1;
                            state_n   = RUN;
                        end
                        4'd2: begin
                            pend_hi_n = r_s;
                            pend_lo_n = q_s;
                            cnt_n     = 4'(DIV_CYCLES);
                            busy_n    = 1'b1;
                            state_n   = RUN;
                        end
                        4'd3: begin
                            pend_hi_n = r_u;
                            pend_lo_n = q_u;
                            cnt_n     = 4'(DIV_CYCLES);
                            busy_n    = 1'b1;
                            state_n   = RUN;
                        end
                        4'd4:    hi_n = A;
                        4'd5:    lo_n = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Start is ignored here; the hazard unit keeps it from arriving.
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    hi_n    = pend_hi;
                    lo_n    = pend_lo;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            Busy    <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            Busy    <= busy_n;
            HI      <= hi_n;
            LO      <= lo_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
        end
    end

    assign HILOOut = HILOSel ? HI : LO;
endmodule
